// File: rtl/mem_burst_master.sv
// mem_burst_master: turns one line request into LINE_WORDS back-to-back accesses
// on a single-port synchronous memory (1-cycle read latency).
// Read words stream out on rdata; write words are taken from wdata with a valid/ready handshake.
// Optional feature macro: MEM_BURST_WRAP_EN. When it is defined, a read burst starts at the
// requested word (critical word first) and wraps within the line. Writes always start at offset 0.
module mem_burst_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic                  clka,
    input  logic                  rsta,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  wdata_valid,
    output logic                  wdata_ready,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  rdata_valid,
    output logic                  rdata_last,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  done,
    output logic                  mem_ena,
    output logic                  mem_wea,
    output logic [ADDR_WIDTH-1:0] mem_addra,
    output logic [DATA_WIDTH-1:0] mem_dina,
    input  logic [DATA_WIDTH-1:0] mem_douta
);

    localparam int OFS_W = $clog2(LINE_WORDS);
    localparam logic [OFS_W-1:0] LAST_BEAT = OFS_W'(LINE_WORDS - 1);

`ifdef MEM_BURST_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                      state;
    state_t                      state_next;
    logic [OFS_W-1:0]            beat;
    logic [OFS_W-1:0]            beat_next;
    logic [OFS_W-1:0]            start_ofs;
    logic [OFS_W-1:0]            ofs;
    logic [ADDR_WIDTH-OFS_W-1:0] base_hi;
    logic                        rd_vld_p1;
    logic                        accept;

    assign accept = req_valid && (state == S_IDLE);

    // Offset within the line wraps naturally in OFS_W bits, so the upper address never carries.
    assign ofs       = beat + start_ofs;
    assign mem_addra = {base_hi, ofs};

    // Read data is the memory output passed straight through, qualified by the issue-delayed valid.
    assign rdata_valid = rd_vld_p1;
    assign rdata_last  = (state == S_DRAIN);
    assign rdata       = rd_vld_p1 ? mem_douta : '0;

    // State register; an asserted reset abandons any burst in flight.
    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Beat counter: counts issued reads or accepted write words, cleared on request accept.
    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            beat <= '0;
        end else begin
            beat <= beat_next;
        end
    end

    // Read valid tracks "a read was issued last cycle" to match the memory's 1-cycle latency.
    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            rd_vld_p1 <= 1'b0;
        end else begin
            rd_vld_p1 <= (state == S_READ);
        end
    end

    // Request address capture; pure data, so it needs no reset.
    always_ff @(posedge clka) begin
        if (accept) begin
            base_hi   <= req_addr[ADDR_WIDTH-1:OFS_W];
            start_ofs <= (WRAP_EN && !req_write) ? req_addr[OFS_W-1:0] : '0;
        end
    end

    // Next-state and memory-side outputs.
    always_comb begin
        state_next  = state;
        beat_next   = beat;
        req_ready   = 1'b0;
        wdata_ready = 1'b0;
        mem_ena     = 1'b0;
        mem_wea     = 1'b0;
        mem_dina    = '0;
        done        = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = req_write ? S_WRITE : S_READ;
                    beat_next  = '0;
                end
            end
            S_READ: begin
                mem_ena   = 1'b1;
                beat_next = beat + OFS_W'(1);
                if (beat == LAST_BEAT) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            S_WRITE: begin
                wdata_ready = 1'b1;
                if (wdata_valid) begin
                    mem_ena   = 1'b1;
                    mem_wea   = 1'b1;
                    mem_dina  = wdata;
                    beat_next = beat + OFS_W'(1);
                    if (beat == LAST_BEAT) begin
                        state_next = S_DONE;
                    end
                end
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_burst_master.sv
// Testbench for mem_burst_master (ADDR_WIDTH=8, DATA_WIDTH=32, LINE_WORDS=4).
// A behavioural memory plus a reference model (expected access / read-data queues and a
// shadow memory) checks every memory access and every read word; directed cases pin the
// model with literal addresses and data. Honours MEM_BURST_WRAP_EN when defined.
module tb_mem_burst_master;

`ifdef MEM_BURST_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic        clka = 1'b0;
    logic        rsta;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [7:0]  req_addr;
    logic        wdata_valid;
    logic        wdata_ready;
    logic [31:0] wdata;
    logic        rdata_valid;
    logic        rdata_last;
    logic [31:0] rdata;
    logic        done;
    logic        mem_ena;
    logic        mem_wea;
    logic [7:0]  mem_addra;
    logic [31:0] mem_dina;
    logic [31:0] mem_douta;

    always #5 clka = ~clka;

    mem_burst_master #(
        .ADDR_WIDTH(8),
        .DATA_WIDTH(32),
        .LINE_WORDS(4)
    ) dut (
        .clka(clka),
        .rsta(rsta),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr(req_addr),
        .wdata_valid(wdata_valid),
        .wdata_ready(wdata_ready),
        .wdata(wdata),
        .rdata_valid(rdata_valid),
        .rdata_last(rdata_last),
        .rdata(rdata),
        .done(done),
        .mem_ena(mem_ena),
        .mem_wea(mem_wea),
        .mem_addra(mem_addra),
        .mem_dina(mem_dina),
        .mem_douta(mem_douta)
    );

    // Behavioural single-port memory with 1-cycle read latency
    logic [31:0] mem [256];
    always @(posedge clka) begin
        if (mem_ena) begin
            if (mem_wea) mem[mem_addra] <= mem_dina;
            else         mem_douta      <= mem[mem_addra];
        end
    end

    // Reference model state
    typedef struct packed {
        logic [7:0]  a;
        logic        we;
        logic [31:0] d;
    } acc_t;
    typedef struct packed {
        logic [31:0] d;
        logic        last;
    } rd_t;

    logic [31:0] ref_mem [256];
    acc_t        exp_acc [$];
    rd_t         exp_rd  [$];
    int          exp_done = 0;
    int          checks   = 0;
    int          errors   = 0;

    logic [7:0]  cap_addr [4];
    logic [31:0] cap_data [4];
    logic [7:0]  lit3e    [4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%b required=%b t=%0t", nm, act, req, $time);
        end
    endtask

    // Address of the k-th access of a burst, from the line/offset rules
    function automatic logic [7:0] beat_addr(input logic [7:0] a, input int k, input bit rd);
        logic [1:0] o;
        o = (WRAP && rd) ? 2'(int'(a[1:0]) + k) : 2'(k);
        return {a[7:2], o};
    endfunction

    // Per-cycle compare against the model queues
    acc_t ce;
    rd_t  cr;
    always @(negedge clka) begin
        if (!rsta) begin
            if (mem_ena) begin
                if (exp_acc.size() == 0) begin
                    chk1("unexp_acc", mem_ena, 1'b0);
                end else begin
                    ce = exp_acc.pop_front();
                    chk("acc_addr", 32'(mem_addra), 32'(ce.a));
                    chk1("acc_we", mem_wea, ce.we);
                    if (ce.we) chk("acc_data", mem_dina, ce.d);
                end
            end else begin
                chk1("wea_no_ena", mem_wea, 1'b0);
            end
            if (!(mem_ena && mem_wea)) chk("dina_zero", mem_dina, 32'd0);
            if (rdata_valid) begin
                if (exp_rd.size() == 0) begin
                    chk1("unexp_rdata", rdata_valid, 1'b0);
                end else begin
                    cr = exp_rd.pop_front();
                    chk("rdata", rdata, cr.d);
                    chk1("rdata_last", rdata_last, cr.last);
                    chk1("done_with_last", done, rdata_last);
                end
            end else begin
                chk1("last_no_valid", rdata_last, 1'b0);
            end
            if (done) begin
                if (exp_done == 0) chk1("unexp_done", done, 1'b0);
                else exp_done--;
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (!req_ready && n < 100) begin
            @(posedge clka);
            #1;
            n++;
        end
        if (!req_ready) begin
            errors++;
            $display("FAIL wait_idle actual=busy required=idle t=%0t", $time);
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $fatal(1, "request never accepted");
        end
    endtask

    task automatic do_read(input logic [7:0] a, input bit hold);
        acc_t e;
        rd_t  r;
        wait_idle();
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = a;
        for (int k = 0; k < 4; k++) begin
            e.a = beat_addr(a, k, 1'b1);
            e.we = 1'b0;
            e.d = 32'd0;
            exp_acc.push_back(e);
            r.d = ref_mem[e.a];
            r.last = (k == 3);
            exp_rd.push_back(r);
        end
        exp_done++;
        @(posedge clka);
        #1;
        if (!hold) req_valid = 1'b0;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(negedge clka);
            chk1("rd_ena_timing", mem_ena, cyc <= 4);
            chk1("rd_valid_timing", rdata_valid, cyc >= 2 && cyc <= 5);
            chk1("rd_done_timing", done, cyc == 5);
            chk1("rd_ready_timing", req_ready, cyc == 6);
            if (cyc <= 4) cap_addr[cyc-1] = mem_addra;
            if (cyc >= 2 && cyc <= 5) cap_data[cyc-2] = rdata;
        end
    endtask

    task automatic do_write(input logic [7:0] a, input logic [127:0] words,
                            input int gap_beat, input int gap_len, input bit rst_mid);
        acc_t e;
        wait_idle();
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = a;
        for (int k = 0; k < (rst_mid ? 2 : 4); k++) begin
            e.a = beat_addr(a, k, 1'b0);
            e.we = 1'b1;
            e.d = words[32*k +: 32];
            exp_acc.push_back(e);
            ref_mem[e.a] = e.d;
        end
        if (!rst_mid) exp_done++;
        @(posedge clka);
        #1;
        req_valid = 1'b0;
        req_write = 1'b0;
        for (int b = 0; b < 4; b++) begin
            if (b == gap_beat) begin
                for (int g = 0; g < gap_len; g++) begin
                    wdata_valid = 1'b0;
                    @(negedge clka);
                    chk1("gap_no_access", mem_ena, 1'b0);
                    @(posedge clka);
                    #1;
                end
            end
            if (rst_mid && b == 2) begin
                wdata_valid = 1'b1;
                wdata = words[64 +: 32];
                #1 rsta = 1'b1;
                #1;
                chk1("rst_ena_drop", mem_ena, 1'b0);
                chk1("rst_no_done", done, 1'b0);
                @(posedge clka);
                #1;
                @(posedge clka);
                #1 rsta = 1'b0;
                for (int i = 0; i < 2; i++) begin
                    @(negedge clka);
                    chk1("post_rst_no_ena", mem_ena, 1'b0);
                    chk1("post_rst_no_wready", wdata_ready, 1'b0);
                    chk1("post_rst_ready", req_ready, 1'b1);
                    @(posedge clka);
                    #1;
                end
                wdata_valid = 1'b0;
                return;
            end
            wdata_valid = 1'b1;
            wdata = words[32*b +: 32];
            @(negedge clka);
            chk1("wr_wready", wdata_ready, 1'b1);
            chk1("wr_busy", req_ready, 1'b0);
            @(posedge clka);
            #1;
        end
        wdata_valid = 1'b0;
        wdata = 32'd0;
        @(negedge clka);
        chk1("wr_done_pulse", done, 1'b1);
        chk1("wr_done_busy", req_ready, 1'b0);
        @(posedge clka);
        #1;
        @(negedge clka);
        chk1("wr_idle_ready", req_ready, 1'b1);
        chk1("wr_done_once", done, 1'b0);
    endtask

    logic [31:0] old52;
    logic [7:0]  ra;

    initial begin
        rsta        = 1'b1;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_addr    = 8'd0;
        wdata_valid = 1'b0;
        wdata       = 32'd0;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        for (int i = 0; i < 4; i++) begin
            mem[8'h10 + i]     = 32'hA0 + i;
            ref_mem[8'h10 + i] = 32'hA0 + i;
        end
        if (WRAP) begin
            lit3e[0] = 8'h3E; lit3e[1] = 8'h3F; lit3e[2] = 8'h3C; lit3e[3] = 8'h3D;
        end else begin
            lit3e[0] = 8'h3C; lit3e[1] = 8'h3D; lit3e[2] = 8'h3E; lit3e[3] = 8'h3F;
        end

        #2;
        chk1("reset_req_ready", req_ready, 1'b1);
        chk1("reset_mem_ena", mem_ena, 1'b0);
        chk1("reset_rdata_valid", rdata_valid, 1'b0);
        chk1("reset_done", done, 1'b0);
        chk1("reset_wdata_ready", wdata_ready, 1'b0);
        repeat (2) @(posedge clka);
        #1 rsta = 1'b0;

        // Basic read
        do_read(8'h10, 1'b0);
        for (int k = 0; k < 4; k++) begin
            chk("read10_addr", 32'(cap_addr[k]), 32'h10 + k);
            chk("read10_data", cap_data[k], 32'hA0 + k);
        end

        // Write with a two-cycle valid gap, then read back
        do_write(8'h20, {32'hB3, 32'hB2, 32'hB1, 32'hB0}, 2, 2, 1'b0);
        do_read(8'h20, 1'b0);
        for (int k = 0; k < 4; k++) chk("readback20", cap_data[k], 32'hB0 + k);

        // Unaligned request: critical word first or aligned, by build
        do_read(8'h3E, 1'b0);
        for (int k = 0; k < 4; k++) chk("read3e_addr", 32'(cap_addr[k]), 32'(lit3e[k]));

        // Top of the address space: no carry into upper bits
        do_read(8'hFC, 1'b0);
        for (int k = 0; k < 4; k++) chk("readfc_addr", 32'(cap_addr[k]), 32'hFC + k);

        // Reset in the middle of a write burst, then a normal request
        old52 = ref_mem[8'h52];
        do_write(8'h50, {32'hC3, 32'hC2, 32'hC1, 32'hC0}, 4, 0, 1'b1);
        do_read(8'h50, 1'b0);
        chk("rst_word0", cap_data[0], 32'hC0);
        chk("rst_word1", cap_data[1], 32'hC1);
        chk("rst_word2_kept", cap_data[2], old52);

        // Request held high through a burst is only taken again from IDLE
        do_read(8'h40, 1'b1);
        do_read(8'h44, 1'b0);

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            ra = 8'($urandom);
            if ($urandom_range(0, 1) == 1)
                do_write(ra, {$urandom, $urandom, $urandom, $urandom},
                         int'($urandom_range(0, 4)), int'($urandom_range(1, 3)), 1'b0);
            else
                do_read(ra, 1'b0);
        end

        repeat (3) @(posedge clka);
        #1;
        chk("acc_left", 32'(exp_acc.size()), 32'd0);
        chk("rd_left", 32'(exp_rd.size()), 32'd0);
        chk("done_left", 32'(exp_done), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
